facto_host: RTL and testbench

- Bus initiator that drives the FactoCore slave register interface on behalf of a simple request/response client.
- For each request it runs the fixed register sequence: clear, clear-down, interrupt-enable, operand, start.
- It then waits for completion, either by polling opdone or by waiting on interrupt, reads result_h/result_l, and returns them.
- It sits between a client and a FactoCore instance and is the master end of the s_* bus.

---
 rtl/facto_pkg.sv | 45 ++++
 rtl/facto_host.sv | 168 ++++++++++++++++
 tb/tb_facto_host.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/facto_pkg.sv
// Shared definitions for the FactoCore bus host: register map, FSM states and
// the registered bus-cycle bundle.
package facto_pkg;

  localparam int DATA_W = 64;

  localparam logic [15:0] OFS_START    = 16'h0000;
  localparam logic [15:0] OFS_CLEAR    = 16'h0008;
  localparam logic [15:0] OFS_OPDONE   = 16'h0010;
  localparam logic [15:0] OFS_INTREN   = 16'h0018;
  localparam logic [15:0] OFS_OPERAND  = 16'h0020;
  localparam logic [15:0] OFS_RESULT_H = 16'h0028;
  localparam logic [15:0] OFS_RESULT_L = 16'h0030;

  typedef enum logic [3:0] {
    IDLE, CLR, CLR_DN, WR_INTEN, WR_OPND, START,
    WAIT, RD_H, RD_L, ABORT_CLR, ABORT_DN, RSP
  } state_e;

  typedef struct packed {
    logic              sel;
    logic              wr;
    logic [15:0]       addr;
    logic [DATA_W-1:0] dout;
  } bus_t;

  function automatic bus_t bus_write(input logic [15:0] addr, input logic [DATA_W-1:0] data);
    bus_t b;
    b.sel  = 1'b1;
    b.wr   = 1'b1;
    b.addr = addr;
    b.dout = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [15:0] addr);
    bus_t b;
    b.sel  = 1'b1;
    b.wr   = 1'b0;
    b.addr = addr;
    b.dout = '0;
    return b;
  endfunction

endpackage

// File: rtl/facto_host.sv
// Bus master that runs one FactoCore factorial job per client request:
// program the core, wait for done (poll or interrupt), read the 128-bit result.
module facto_host
  import facto_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'h7000,
  parameter int          POLL_GAP = 4,
  parameter int          TIMEOUT  = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_operand,
  input  logic              req_use_intr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result_h,
  output logic [DATA_W-1:0] rsp_result_l,
  output logic              rsp_error,
  output logic              m_sel,
  output logic              m_wr,
  output logic [15:0]       m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  input  logic              interrupt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int PG_W = $clog2(POLL_GAP + 2);

  state_e            state_q, state_d;
  bus_t              bus_q, bus_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              intr_q, intr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [PG_W-1:0]   pg_cnt_q, pg_cnt_d;
  logic [DATA_W-1:0] res_h_q, res_h_d;
  logic [DATA_W-1:0] res_l_q, res_l_d;
  logic              err_q, err_d;
  logic              done;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    bus_d    = bus_q;
    bus_d.sel = 1'b0;
    bus_d.wr  = 1'b0;
    opnd_d   = opnd_q;
    intr_d   = intr_q;
    to_cnt_d = to_cnt_q;
    pg_cnt_d = pg_cnt_q;
    res_h_d  = res_h_q;
    res_l_d  = res_l_q;
    err_d    = err_q;
    done     = 1'b0;

    case (state_q)
      IDLE: if (req_valid) begin
        opnd_d  = req_operand;
        intr_d  = req_use_intr;
        res_h_d = '0;
        res_l_d = '0;
        err_d   = 1'b0;
        state_d = CLR;
        bus_d   = bus_write(BASE + OFS_CLEAR, 64'd1);
      end
      CLR: begin
        state_d = CLR_DN;
        bus_d   = bus_write(BASE + OFS_CLEAR, 64'd0);
      end
      CLR_DN: begin
        state_d = WR_INTEN;
        bus_d   = bus_write(BASE + OFS_INTREN, {63'b0, intr_q});
      end
      WR_INTEN: begin
        state_d = WR_OPND;
        bus_d   = bus_write(BASE + OFS_OPERAND, opnd_q);
      end
      WR_OPND: begin
        state_d = START;
        bus_d   = bus_write(BASE + OFS_START, 64'd1);
      end
      START: begin
        state_d  = WAIT;
        to_cnt_d = '0;
        pg_cnt_d = PG_W'(POLL_GAP);
        if (!intr_q) bus_d = bus_read(BASE + OFS_OPDONE);
      end
      WAIT: begin
        // In poll mode the only WAIT bus cycles are opdone reads, so sel marks a valid sample.
        done = intr_q ? interrupt : (bus_q.sel & m_din[0]);
        if (done) begin
          state_d = RD_H;
          bus_d   = bus_read(BASE + OFS_RESULT_H);
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ABORT_CLR;
          bus_d   = bus_write(BASE + OFS_CLEAR, 64'd1);
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (!intr_q) begin
            if (pg_cnt_q == '0) begin
              bus_d    = bus_read(BASE + OFS_OPDONE);
              pg_cnt_d = PG_W'(POLL_GAP);
            end else begin
              pg_cnt_d = pg_cnt_q - 1'b1;
            end
          end
        end
      end
      RD_H: begin
        res_h_d = m_din;
        state_d = RD_L;
        bus_d   = bus_read(BASE + OFS_RESULT_L);
      end
      RD_L: begin
        res_l_d = m_din;
        state_d = RSP;
      end
      ABORT_CLR: begin
        state_d = ABORT_DN;
        bus_d   = bus_write(BASE + OFS_CLEAR, 64'd0);
      end
      ABORT_DN: begin
        err_d   = 1'b1;
        state_d = RSP;
      end
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bus_q    <= '{sel: 1'b0, wr: 1'b0, addr: BASE, dout: '0};
      opnd_q   <= '0;
      intr_q   <= 1'b0;
      to_cnt_q <= '0;
      pg_cnt_q <= '0;
      res_h_q  <= '0;
      res_l_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      opnd_q   <= opnd_d;
      intr_q   <= intr_d;
      to_cnt_q <= to_cnt_d;
      pg_cnt_q <= pg_cnt_d;
      res_h_q  <= res_h_d;
      res_l_q  <= res_l_d;
      err_q    <= err_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RSP);
  assign rsp_result_h = res_h_q;
  assign rsp_result_l = res_l_q;
  assign rsp_error    = err_q;
  assign m_sel        = bus_q.sel;
  assign m_wr         = bus_q.wr;
  assign m_addr       = bus_q.addr;
  assign m_dout       = bus_q.dout;

endmodule

// File: tb/tb_facto_host.sv
// Randomized bench for facto_host with a behavioural FactoCore slave, a bus
// trace monitor and a rule-level reference model of the expected transaction.
module tb_facto_host;
  import facto_pkg::*;

  localparam logic [15:0] BASE     = 16'h7000;
  localparam int          POLL_GAP = 4;
  localparam int          TIMEOUT  = 64;
  localparam int          PERIOD   = POLL_GAP + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_use_intr = 1'b0;
  logic [63:0] req_operand = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_error;
  logic [63:0] rsp_result_h, rsp_result_l;
  logic        m_sel, m_wr, interrupt;
  logic [15:0] m_addr;
  logic [63:0] m_dout, m_din;

  facto_host #(.BASE(BASE), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
    .req_use_intr(req_use_intr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result_h(rsp_result_h), .rsp_result_l(rsp_result_l), .rsp_error(rsp_error),
    .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (int i = 2; i <= int'(n); i++) r = r * i;
    return r;
  endfunction

  // Behavioural FactoCore slave: completes slave_lat cycles after START, or never when stubbed.
  int           slave_lat  = 0;
  bit           slave_stub = 1'b0;
  logic         s_done = 1'b0, s_busy = 1'b0, s_intren = 1'b0;
  int           s_cnt = 0;
  logic [63:0]  s_opnd = '0;
  logic [127:0] s_res = '0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
    int          cyc;
  } trans_t;

  trans_t log_q[$];
  trans_t mon;
  int     cyc = 0;

  always_comb begin
    m_din = '0;
    case (m_addr)
      BASE + OFS_OPDONE:   m_din = {63'b0, s_done};
      BASE + OFS_RESULT_H: m_din = s_res[127:64];
      BASE + OFS_RESULT_L: m_din = s_res[63:0];
      default:             m_din = '0;
    endcase
  end
  assign interrupt = s_done & s_intren;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_sel) begin
      mon.wr = m_wr; mon.addr = m_addr; mon.data = m_dout; mon.cyc = cyc;
      log_q.push_back(mon);
    end
    if (s_busy && !slave_stub) begin
      if (s_cnt == 0) begin
        s_done <= 1'b1; s_busy <= 1'b0; s_res <= fact(s_opnd);
      end else s_cnt <= s_cnt - 1;
    end
    if (m_sel && m_wr) begin
      case (m_addr)
        BASE + OFS_CLEAR:   if (m_dout[0]) begin s_done <= 1'b0; s_busy <= 1'b0; s_res <= '0; end
        BASE + OFS_INTREN:  s_intren <= m_dout[0];
        BASE + OFS_OPERAND: s_opnd <= m_dout;
        BASE + OFS_START: if (m_dout[0]) begin
          if (slave_lat == 0 && !slave_stub) begin
            s_done <= 1'b1; s_res <= fact(s_opnd);
          end else begin
            s_busy <= 1'b1; s_cnt <= slave_lat - 1;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic run_req(input logic [63:0] op, input logic intr, input int lat,
                         input bit stub, input int hold);
    int n, start_idx, n_ent, detect, exp_reads, start_cyc;
    bit exp_err;
    logic [127:0] exp_res;
    logic [15:0] w_addr [5];
    logic [63:0] w_data [5];
    trans_t e;

    // Reference: WAIT cycle index at which done is first observed.
    detect  = intr ? lat : ((lat + POLL_GAP) / PERIOD) * PERIOD;
    exp_err = stub || (detect > TIMEOUT - 1);
    exp_res = exp_err ? 128'd0 : fact(op);
    if (intr) exp_reads = 0;
    else exp_reads = exp_err ? (TIMEOUT - 1) / PERIOD + 1 : detect / PERIOD + 1;

    slave_lat = lat; slave_stub = stub;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1);
    start_idx = log_q.size();
    if (hold > 0) rsp_ready = 1'b0;
    req_operand = op; req_use_intr = intr; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    n = 1;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    check("rsp_valid_seen", rsp_valid, 1);
    if (intr && lat == 0 && !stub) check("latency_cycles", n, 9);
    check("rsp_error", rsp_error, exp_err);
    check("rsp_result_h", rsp_result_h, exp_res[127:64]);
    check("rsp_result_l", rsp_result_l, exp_res[63:0]);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_result", {rsp_result_h, rsp_result_l}, exp_res);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid_clear", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);

    w_addr[0] = BASE + OFS_CLEAR;   w_data[0] = 64'd1;
    w_addr[1] = BASE + OFS_CLEAR;   w_data[1] = 64'd0;
    w_addr[2] = BASE + OFS_INTREN;  w_data[2] = {63'b0, intr};
    w_addr[3] = BASE + OFS_OPERAND; w_data[3] = op;
    w_addr[4] = BASE + OFS_START;   w_data[4] = 64'd1;
    n_ent = log_q.size() - start_idx;
    check("trace_len", n_ent, 5 + exp_reads + 2);
    if (n_ent >= 7) begin
      for (int i = 0; i < 5; i++) begin
        e = log_q[start_idx + i];
        check("setup_write", {e.wr, e.addr, e.data}, {1'b1, w_addr[i], w_data[i]});
      end
      start_cyc = log_q[start_idx + 4].cyc;
      for (int i = 5; i < n_ent - 2; i++) begin
        e = log_q[start_idx + i];
        check("opdone_read", {e.wr, e.addr, 32'(e.cyc - start_cyc)},
              {1'b0, BASE + OFS_OPDONE, 32'(1 + PERIOD * (i - 5))});
      end
      e = log_q[start_idx + n_ent - 2];
      if (exp_err)
        check("abort_clr", {e.wr, e.addr, e.data, 32'(e.cyc - start_cyc)},
              {1'b1, BASE + OFS_CLEAR, 64'd1, 32'(TIMEOUT + 1)});
      else
        check("rd_h", {e.wr, e.addr, 32'(e.cyc - start_cyc)},
              {1'b0, BASE + OFS_RESULT_H, 32'(detect + 2)});
      e = log_q[start_idx + n_ent - 1];
      if (exp_err)
        check("abort_dn", {e.wr, e.addr, e.data}, {1'b1, BASE + OFS_CLEAR, 64'd0});
      else
        check("rd_l", {e.wr, e.addr}, {1'b0, BASE + OFS_RESULT_L});
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_error, rsp_result_h, rsp_result_l}, '0);
    check("rst_bus", {m_sel, m_wr, m_addr, m_dout}, {2'b00, BASE, 64'd0});
    reset_n = 1'b1;
    @(negedge clk);

    run_req(64'd5, 1'b0, 3, 1'b0, 0);
    check("fact5_l", rsp_result_l, 64'd120);
    run_req(64'd0, 1'b1, 0, 1'b0, 0);
    run_req(64'd1, 1'b1, 0, 1'b0, 0);
    run_req(64'd16, 1'b0, 12, 1'b0, 0);
    run_req(64'd7, 1'b0, 0, 1'b1, 0);
    run_req(64'd9, 1'b1, 63, 1'b0, 0);
    run_req(64'd9, 1'b1, 64, 1'b0, 0);
    run_req(64'd11, 1'b0, 60, 1'b0, 0);
    run_req(64'd11, 1'b0, 61, 1'b0, 0);
    run_req(64'd20, 1'b1, 5, 1'b0, 10);
    for (int i = 0; i < 12; i++)
      run_req(64'($urandom_range(0, 30)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 70)), 1'b0, int'($urandom_range(0, 3)));

    // Reset in the middle of a WAIT phase, then rerun the same job.
    slave_lat = 40; slave_stub = 1'b0;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    n = log_q.size();
    req_operand = 64'd18; req_use_intr = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 50 && log_q.size() < n + 5; i++) @(negedge clk);
    check("pre_reset_start", log_q.size() >= n + 5, 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_bus", {m_sel, m_wr, m_addr}, {2'b00, BASE});
    check("mid_rst_ready", {req_ready, rsp_valid}, 2'b10);
    @(negedge clk);
    reset_n = 1'b1;
    run_req(64'd18, 1'b0, 20, 1'b0, 0);
    check("fact18_l", rsp_result_l, 64'h0016_BEEC_CA73_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
